// File: rtl/poly_sub_seq_if.sv
// Handshake and operand/result bundle for poly_sub_seq.
// The master (requester) drives start and operands; the slave (poly_sub_seq)
// returns busy, done and the result polynomial.
interface poly_sub_seq_if #(
  parameter int DEG = 4,
  parameter int N   = 4
);
  logic             start;
  logic [DEG*N-1:0] a;
  logic [DEG*N-1:0] b;
  logic             busy;
  logic             done;
  logic [DEG*N-1:0] d;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input d);
  modport slave  (input  start, input  a, input b,
                  output busy,  output done, output d);
endinterface

// File: rtl/poly_sub_seq.sv
// Coefficient-serial modular polynomial subtractor: d = a - b mod Q,
// one coefficient per clock, with a start/busy/done handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; d holds the last result
// RUN    | writing coefficient idx of d each cycle, DEG cycles total
// DONE   | one-cycle done pulse, busy still high, then back to IDLE
module poly_sub_seq #(
  parameter int DEG = 4,
  parameter int N   = 4,
  parameter int Q   = 13
) (
  input  logic            clk,
  input  logic            rst,
  poly_sub_seq_if.slave   bus
);

  localparam int IW = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [N:0] QV = (N+1)'(Q);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [DEG*N-1:0] r_a;
  logic [DEG*N-1:0] r_b;
  logic [DEG*N-1:0] r_d;

  logic [N-1:0]     w_ai;
  logic [N-1:0]     w_bi;
  logic [N:0]       w_t;
  logic [N-1:0]     w_di;

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.d    = r_d;

  // Select the coefficient pair addressed by idx from the latched operands.
  always_comb begin
    w_ai = '0;
    w_bi = '0;
    for (int i = 0; i < DEG; i++) begin
      if (r_idx == IW'(i)) begin
        w_ai = r_a[i*N +: N];
        w_bi = r_b[i*N +: N];
      end
    end
  end

  // Borrow-corrected difference; out-of-range inputs are not reduced,
  // the same formula just gets truncated to N bits.
  assign w_t  = {1'b0, w_ai} - {1'b0, w_bi};
  assign w_di = N'(w_t[N] ? (w_t + QV) : w_t);

  // Sequencer: latch operands on accept, write one coefficient per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < DEG; i++) begin
            if (r_idx == IW'(i)) r_d[i*N +: N] <= w_di;
          end
          if (r_idx == IW'(DEG-1)) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sub_seq.sv
// Scoreboard bench for poly_sub_seq: one instance with Q=13, one with Q=16.
// Stimulus pushes expected {d, done cycle}; monitors pop on each done pulse.
module tb_poly_sub_seq;

  localparam int DEG = 4;
  localparam int N   = 4;

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q13[$];
  exp_t q16[$];
  bit   seen13;
  bit   seen16;

  poly_sub_seq_if #(.DEG(DEG), .N(N)) if13 ();
  poly_sub_seq_if #(.DEG(DEG), .N(N)) if16 ();

  poly_sub_seq #(.DEG(DEG), .N(N), .Q(13)) u13 (.clk(clk), .rst(rst), .bus(if13));
  poly_sub_seq #(.DEG(DEG), .N(N), .Q(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor for the Q=13 instance.
  always @(negedge clk) begin
    exp_t e;
    if (seen13) begin
      check("busy_after_done13", {31'd0, if13.busy}, 32'd0);
      seen13 = 1'b0;
    end
    if (if13.done === 1'b1) begin
      seen13 = 1'b1;
      if (q13.size() == 0) begin
        check("unexpected_done13", 32'd1, 32'd0);
      end else begin
        e = q13.pop_front();
        check("d13", {16'd0, if13.d}, {16'd0, e.d});
        check("latency13", cyc, e.cyc);
      end
    end
  end

  // Monitor for the Q=16 instance.
  always @(negedge clk) begin
    exp_t e;
    if (seen16) begin
      check("busy_after_done16", {31'd0, if16.busy}, 32'd0);
      seen16 = 1'b0;
    end
    if (if16.done === 1'b1) begin
      seen16 = 1'b1;
      if (q16.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        check("d16", {16'd0, if16.d}, {16'd0, e.d});
        check("latency16", cyc, e.cyc);
      end
    end
  end

  task automatic push_exp(input bit s16, input logic [15:0] ev, input int c);
    exp_t e;
    e.d   = ev;
    e.cyc = c;
    if (s16) q16.push_back(e);
    else     q13.push_back(e);
  endtask

  task automatic drive(input bit s16, input logic st, input logic [15:0] av, input logic [15:0] bv);
    if (s16) begin
      if16.start = st; if16.a = av; if16.b = bv;
    end else begin
      if13.start = st; if13.a = av; if13.b = bv;
    end
  endtask

  task automatic wait_idle(input bit s16);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (s16) begin
        if (q16.size() == 0 && if16.busy === 1'b0) begin ok = 1'b1; break; end
      end else begin
        if (q13.size() == 0 && if13.busy === 1'b0) begin ok = 1'b1; break; end
      end
    end
    if (!ok) check("timeout_idle", 32'd0, 32'd1);
  endtask

  // Start one operation from IDLE, record its expected result, wait for it.
  task automatic run_op(input bit s16, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ev);
    @(posedge clk); #1;
    drive(s16, 1'b1, av, bv);
    @(posedge clk); #1;
    push_exp(s16, ev, cyc + DEG);
    drive(s16, 1'b0, ~av, ~bv);
    wait_idle(s16);
  endtask

  initial begin
    int e0;
    checks = 0;
    errors = 0;
    seen13 = 1'b0;
    seen16 = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 16'h0, 16'h0);

    // Reset with a start pulse during reset.
    rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'hC5A3, 16'h1B27);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("rst_busy", {31'd0, if13.busy}, 32'd0);
    check("rst_done", {31'd0, if13.done}, 32'd0);
    check("rst_d", {16'd0, if13.d}, 32'd0);
    check("rst_d16", {16'd0, if16.d}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_start_after_rst", {31'd0, if13.busy}, 32'd0);

    // Mixed borrow, Q=13.
    run_op(1'b0, 16'hC5A3, 16'h1B27, 16'hB789);
    // Q=16 wrap-around.
    run_op(1'b1, 16'hAA5F, 16'hAA5F, 16'h0000);
    run_op(1'b1, 16'h0000, 16'h0001, 16'h000F);
    run_op(1'b1, 16'h1234, 16'h4321, 16'hDF13);
    // More Q=13 patterns, including unreduced inputs >= Q.
    run_op(1'b0, 16'hCCCC, 16'h0000, 16'hCCCC);
    run_op(1'b0, 16'h0000, 16'hCCCC, 16'h1111);
    run_op(1'b0, 16'h00F0, 16'h000F, 16'h00FE);

    // Start ignored while busy.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'hC5A3, 16'h1B27);
    @(posedge clk); #1;
    push_exp(1'b0, 16'hB789, cyc + DEG);
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_idle(1'b0);
    repeat (8) @(negedge clk);
    check("ignored_start_idle", {31'd0, if13.busy}, 32'd0);

    // Reset in the middle of RUN: no done, d cleared.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'hC5A3, 16'h1B27);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, if13.busy}, 32'd0);
    check("midrst_d", {16'd0, if13.d}, 32'd0);
    repeat (6) @(negedge clk);
    check("midrst_still_idle", {31'd0, if13.busy}, 32'd0);
    run_op(1'b0, 16'h0001, 16'h0002, 16'h000C);

    // Back-to-back with start held: accepts every DEG+2 cycles.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h3210, 16'h0123);
    @(posedge clk); #1;
    e0 = cyc;
    push_exp(1'b0, 16'h31CA, e0 + DEG);
    push_exp(1'b0, 16'h31CA, e0 + 2*DEG + 2);
    push_exp(1'b0, 16'h31CA, e0 + 3*DEG + 4);
    repeat (2*DEG + 4) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    wait_idle(1'b0);
    repeat (10) @(negedge clk);

    check("q13_drained", q13.size(), 32'd0);
    check("q16_drained", q16.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
